// File: rtl/mpu_scalar_mul_seq_if.sv
// Start/done handshake and matrix bus of the sequential matrix-by-scalar multiplier.
// The master drives the operands and start. The slave returns status and the result.
interface mpu_scalar_mul_seq_if #(
    parameter int DIM   = 5,
    parameter int WIDTH = 8
);
    logic                       start;
    logic [DIM*DIM*WIDTH-1:0]   matrix_a;
    logic [WIDTH-1:0]           factor;
    logic                       signed_mode;
    logic                       saturate;
    logic                       busy;
    logic                       done;
    logic [DIM*DIM*WIDTH-1:0]   result;
    logic                       overflow;

    modport master (
        output start, matrix_a, factor, signed_mode, saturate,
        input  busy, done, result, overflow
    );

    modport slave (
        input  start, matrix_a, factor, signed_mode, saturate,
        output busy, done, result, overflow
    );
endinterface

// File: rtl/mpu_scalar_mul_seq.sv
// Multi-cycle matrix-by-scalar multiplier: LANES elements per clock, signed/unsigned,
// wrap/saturate, sticky overflow, start/done handshake.
module mpu_scalar_mul_seq #(
    parameter int DIM   = 5,
    parameter int WIDTH = 8,
    parameter int LANES = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mpu_scalar_mul_seq_if.slave     bus
);
    localparam int ELEMS = DIM * DIM;
    localparam int FLAT  = ELEMS * WIDTH;
    localparam int STEPS = ELEMS / LANES;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int IDX_W = $clog2(FLAT) + 1;
    localparam int PW    = 2 * WIDTH;

    generate
        if ((ELEMS % LANES) != 0) begin : g_lanes_check
            $error("LANES must divide DIM*DIM");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [FLAT-1:0]     r_mat;
    logic [WIDTH-1:0]    r_factor;
    logic                r_signed;
    logic                r_sat;
    logic                r_busy;
    logic                r_done;
    logic [FLAT-1:0]     r_result;
    logic                r_overflow;

    logic [IDX_W-1:0]    w_idx [LANES];
    logic [WIDTH-1:0]    w_val [LANES];
    logic [LANES-1:0]    w_ovf;
    logic [PW-1:0]       w_f_ext;

    assign w_f_ext = r_signed ? {{WIDTH{r_factor[WIDTH-1]}}, r_factor}
                              : {{WIDTH{1'b0}}, r_factor};

    // Truncating the product of the extended operands to PW bits is exact in both modes.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [WIDTH-1:0] w_a;
            logic [PW-1:0]    w_a_ext;
            logic [PW-1:0]    w_prod;
            logic             w_fit;
            logic [WIDTH-1:0] w_sat_val;

            assign w_idx[gi]  = IDX_W'(r_cnt) * IDX_W'(LANES) + IDX_W'(gi);
            assign w_a        = r_mat[w_idx[gi] * IDX_W'(WIDTH) +: WIDTH];
            assign w_a_ext    = r_signed ? {{WIDTH{w_a[WIDTH-1]}}, w_a}
                                         : {{WIDTH{1'b0}}, w_a};
            assign w_prod     = w_a_ext * w_f_ext;
            assign w_fit      = r_signed ? (w_prod[PW-1:WIDTH-1] == {(WIDTH+1){w_prod[WIDTH-1]}})
                                         : (w_prod[PW-1:WIDTH] == '0);
            assign w_sat_val  = !r_signed     ? {WIDTH{1'b1}} :
                                w_prod[PW-1]  ? {1'b1, {(WIDTH-1){1'b0}}}
                                              : {1'b0, {(WIDTH-1){1'b1}}};
            assign w_val[gi]  = (!w_fit && r_sat) ? w_sat_val : w_prod[WIDTH-1:0];
            assign w_ovf[gi]  = ~w_fit;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_mat      <= '0;
            r_factor   <= '0;
            r_signed   <= 1'b0;
            r_sat      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_mat      <= bus.matrix_a;
                        r_factor   <= bus.factor;
                        r_signed   <= bus.signed_mode;
                        r_sat      <= bus.saturate;
                        r_result   <= '0;
                        r_overflow <= 1'b0;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        r_result[w_idx[l] * IDX_W'(WIDTH) +: WIDTH] <= w_val[l];
                    end
                    r_overflow <= r_overflow | (|w_ovf);
                    if (r_cnt == CNT_W'(STEPS - 1)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_mpu_scalar_mul_seq.sv
// Directed bench for mpu_scalar_mul_seq: timing, wrap/saturate arithmetic, handshake
// corner cases, mid-run reset, and LANES=1/5/25 equivalence.
module tb_mpu_scalar_mul_seq;
    localparam int DIM   = 5;
    localparam int WIDTH = 8;
    localparam int FLAT  = DIM * DIM * WIDTH;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              start;
    logic [FLAT-1:0]   matrix_a;
    logic [WIDTH-1:0]  factor;
    logic              signed_mode;
    logic              saturate;

    int checks = 0;
    int errors = 0;

    mpu_scalar_mul_seq_if #(.DIM(DIM), .WIDTH(WIDTH)) if5  ();
    mpu_scalar_mul_seq_if #(.DIM(DIM), .WIDTH(WIDTH)) if1  ();
    mpu_scalar_mul_seq_if #(.DIM(DIM), .WIDTH(WIDTH)) if25 ();

    assign if5.start = start;   assign if5.matrix_a = matrix_a;   assign if5.factor = factor;
    assign if5.signed_mode = signed_mode;   assign if5.saturate = saturate;
    assign if1.start = start;   assign if1.matrix_a = matrix_a;   assign if1.factor = factor;
    assign if1.signed_mode = signed_mode;   assign if1.saturate = saturate;
    assign if25.start = start;  assign if25.matrix_a = matrix_a;  assign if25.factor = factor;
    assign if25.signed_mode = signed_mode;  assign if25.saturate = saturate;

    mpu_scalar_mul_seq #(.DIM(DIM), .WIDTH(WIDTH), .LANES(5))  u_dut    (.clk(clk), .rst_n(rst_n), .bus(if5.slave));
    mpu_scalar_mul_seq #(.DIM(DIM), .WIDTH(WIDTH), .LANES(1))  u_dut_l1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    mpu_scalar_mul_seq #(.DIM(DIM), .WIDTH(WIDTH), .LANES(25)) u_dut_l25(.clk(clk), .rst_n(rst_n), .bus(if25.slave));

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Element n holds (n+1)*mult.
    function automatic logic [FLAT-1:0] mat_seq(input int mult);
        logic [FLAT-1:0] m = '0;
        for (int n = 0; n < DIM * DIM; n++) m[n*WIDTH +: WIDTH] = WIDTH'((n + 1) * mult);
        return m;
    endfunction

    function automatic logic [FLAT-1:0] mat_one(input int idx, input logic [WIDTH-1:0] val);
        logic [FLAT-1:0] m = '0;
        m[idx*WIDTH +: WIDTH] = val;
        return m;
    endfunction

    task automatic set_op(input logic [FLAT-1:0] m, input logic [WIDTH-1:0] f,
                          input logic sgn, input logic sat);
        matrix_a = m; factor = f; signed_mode = sgn; saturate = sat;
    endtask

    // Pulse start, then wait (bounded) for done on the LANES=5 unit.
    task automatic run_op(input string tag, output int cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (if5.done) begin
                cyc = c;
                break;
            end
        end
        check({tag, "_latency"}, 256'(cyc), 256'd5);
        $display("op %s: cycles=%0d overflow=%0b result=%0h", tag, cyc, if5.overflow, if5.result);
    endtask

    initial begin
        int cyc, d1, d5, d25, ndone;
        logic [FLAT-1:0] m2;

        start = 1'b0;
        set_op('0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick(); tick();
        check("rst_busy", 256'(if5.busy), 256'd0);
        check("rst_done", 256'(if5.done), 256'd0);
        check("rst_ovf",  256'(if5.overflow), 256'd0);
        check("rst_result", 256'(if5.result), 256'd0);
        rst_n = 1'b1;
        tick();

        // LANES sweep: identical results, latencies 25 / 5 / 1.
        set_op(mat_seq(1), 8'd2, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        d1 = 0; d5 = 0; d25 = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (if1.done  && d1  == 0) d1  = c;
            if (if5.done  && d5  == 0) d5  = c;
            if (if25.done && d25 == 0) d25 = c;
        end
        check("sweep_lat_l1",  256'(d1),  256'd25);
        check("sweep_lat_l5",  256'(d5),  256'd5);
        check("sweep_lat_l25", 256'(d25), 256'd1);
        check("sweep_res_l1",  256'(if1.result),  256'(mat_seq(2)));
        check("sweep_res_l5",  256'(if5.result),  256'(mat_seq(2)));
        check("sweep_res_l25", 256'(if25.result), 256'(mat_seq(2)));
        $display("op sweep: latency l1=%0d l5=%0d l25=%0d", d1, d5, d25);

        // Test 1: exact cycle-by-cycle timing.
        set_op(mat_seq(1), 8'd2, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_busy_k", 256'(if5.busy), 256'd1);
        check("t1_res_cleared", 256'(if5.result), 256'd0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("t1_busy_run", 256'(if5.busy), 256'd1);
            check("t1_done_run", 256'(if5.done), 256'd0);
            if (c == 1) check("t1_partial", 256'(if5.result), 256'(mat_seq(2) & {{(FLAT-40){1'b0}}, {40{1'b1}}}));
        end
        tick();
        check("t1_busy_end", 256'(if5.busy), 256'd0);
        check("t1_done", 256'(if5.done), 256'd1);
        check("t1_result", 256'(if5.result), 256'(mat_seq(2)));
        check("t1_ovf", 256'(if5.overflow), 256'd0);
        tick();
        check("t1_done_once", 256'(if5.done), 256'd0);
        check("t1_hold", 256'(if5.result), 256'(mat_seq(2)));
        $display("op t1: result=%0h", if5.result);

        // Test 2: unsigned 200 x 2.
        set_op(mat_one(7, 8'd200), 8'd2, 1'b0, 1'b0);
        run_op("t2_wrap", cyc);
        check("t2_wrap_res", 256'(if5.result), 256'(mat_one(7, 8'd144)));
        check("t2_wrap_ovf", 256'(if5.overflow), 256'd1);
        set_op(mat_one(7, 8'd200), 8'd2, 1'b0, 1'b1);
        run_op("t2_sat", cyc);
        check("t2_sat_res", 256'(if5.result), 256'(mat_one(7, 8'd255)));
        check("t2_sat_ovf", 256'(if5.overflow), 256'd1);

        // Test 3: signed. -100*2 and -3*2; then -128*-1 and 5*-1.
        m2 = mat_one(0, 8'h9C) | mat_one(24, 8'hFD);
        set_op(m2, 8'd2, 1'b1, 1'b0);
        run_op("t3_wrap", cyc);
        check("t3_wrap_res", 256'(if5.result), 256'(mat_one(0, 8'h38) | mat_one(24, 8'hFA)));
        check("t3_wrap_ovf", 256'(if5.overflow), 256'd1);
        set_op(m2, 8'd2, 1'b1, 1'b1);
        run_op("t3_sat", cyc);
        check("t3_sat_res", 256'(if5.result), 256'(mat_one(0, 8'h80) | mat_one(24, 8'hFA)));
        set_op(mat_one(5, 8'h80) | mat_one(6, 8'h05), 8'hFF, 1'b1, 1'b1);
        run_op("t3_negneg", cyc);
        check("t3_negneg_res", 256'(if5.result), 256'(mat_one(5, 8'h7F) | mat_one(6, 8'hFB)));
        check("t3_negneg_ovf", 256'(if5.overflow), 256'd1);
        set_op(mat_one(6, 8'h05), 8'hFF, 1'b1, 1'b1);
        run_op("t3_fit", cyc);
        check("t3_fit_ovf", 256'(if5.overflow), 256'd0);

        // Test 4: start ignored while busy; start held through done -> back-to-back.
        set_op(mat_one(7, 8'd200), 8'd2, 1'b0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        set_op(mat_seq(1), 8'd3, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_busy_mid", 256'(if5.busy), 256'd1);
        tick(); tick();
        set_op(mat_seq(1), 8'd2, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        check("t4_done_a", 256'(if5.done), 256'd1);
        check("t4_res_a", 256'(if5.result), 256'(mat_one(7, 8'd255)));
        check("t4_ovf_a", 256'(if5.overflow), 256'd1);
        tick();
        start = 1'b0;
        check("t4_b2b_busy", 256'(if5.busy), 256'd1);
        check("t4_b2b_ovf_clr", 256'(if5.overflow), 256'd0);
        check("t4_b2b_res_clr", 256'(if5.result), 256'd0);
        check("t4_b2b_done", 256'(if5.done), 256'd0);
        cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (if5.done) begin cyc = c; break; end
        end
        check("t4_b_latency", 256'(cyc), 256'd5);
        check("t4_res_b", 256'(if5.result), 256'(mat_seq(2)));
        $display("op t4: second op cycles=%0d result=%0h", cyc, if5.result);

        // Test 5: reset when cnt=2 with overflow already set.
        set_op(mat_one(3, 8'd200), 8'd2, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        check("t5_ovf_pre", 256'(if5.overflow), 256'd1);
        rst_n = 1'b0;
        tick();
        check("t5_busy", 256'(if5.busy), 256'd0);
        check("t5_done", 256'(if5.done), 256'd0);
        check("t5_ovf", 256'(if5.overflow), 256'd0);
        check("t5_result", 256'(if5.result), 256'd0);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (if5.done) ndone++;
        end
        check("t5_no_done", 256'(ndone), 256'd0);
        set_op(mat_seq(1), 8'd2, 1'b0, 1'b0);
        run_op("t5_after", cyc);
        check("t5_after_res", 256'(if5.result), 256'(mat_seq(2)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
